// File: rtl/disp_pkg.sv
// Shared types for the display arbiter: FSM state encoding, display modes,
// the idle display word and the owner-selection helper.
package disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWN_A  = 2'd1,
      ST_OWN_B  = 2'd2,
      ST_SWITCH = 2'd3
   } disp_state_t;

   typedef enum logic {
      OWNER_A = 1'b0,
      OWNER_B = 1'b1
   } owner_t;

   localparam logic [1:0] MODE_HEX = 2'b00;
   localparam logic [1:0] MODE_OCT = 2'b01;
   localparam logic [1:0] MODE_DEC = 2'b10;

   typedef struct packed {
      logic [15:0] digits;
      logic [3:0]  dp;
      logic [1:0]  mode;
   } disp_word_t;

   localparam disp_word_t IDLE_PATTERN = '{digits: 16'h0000, dp: 4'b0000, mode: MODE_HEX};

   // Contention goes to whichever client did not own the display last.
   function automatic disp_state_t pick_owner(logic ra, logic rb, owner_t last);
      if (ra && rb) return (last == OWNER_B) ? ST_OWN_A : ST_OWN_B;
      if (ra) return ST_OWN_A;
      if (rb) return ST_OWN_B;
      return ST_IDLE;
   endfunction

endpackage

// File: rtl/disp_scan_prescaler.sv
// Scan-tick prescaler: counts 0..SCAN_DIV-1 and flags the terminal count
// as a one-cycle clkenable.
module disp_scan_prescaler #(
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic clock,
   input  logic areset,
   output logic clkenable
);

   localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clock or negedge areset) begin
      if (!areset)          cnt <= '0;
      else if (cnt == LAST) cnt <= '0;
      else                  cnt <= cnt + CW'(1);
   end

   assign clkenable = (cnt == LAST);

endmodule

// File: rtl/disp_arbiter.sv
// Two-client display arbiter with minimum hold and registered display path.
// Optional ownership timeout with re-request lockout: DISP_ARB_TIMEOUT_EN.
module disp_arbiter
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV      = 50000,
   parameter int unsigned HOLD_TICKS    = 16,
   parameter int unsigned TIMEOUT_TICKS = 4096
) (
   input  logic        clock,
   input  logic        areset,
   input  logic        req_a,
   input  logic        req_b,
   input  logic [15:0] data_a,
   input  logic [15:0] data_b,
   input  logic [3:0]  dpin_a,
   input  logic [3:0]  dpin_b,
   input  logic [1:0]  mode_a,
   input  logic [1:0]  mode_b,
   output logic        gnt_a,
   output logic        gnt_b,
   output logic [3:0]  d3,
   output logic [3:0]  d2,
   output logic [3:0]  d1,
   output logic [3:0]  d0,
   output logic        dp3,
   output logic        dp2,
   output logic        dp1,
   output logic        dp0,
   output logic [1:0]  mode,
   output logic        clkenable,
   output disp_state_t dbg_state
);

   localparam int unsigned HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

   disp_state_t   state, nxt;
   owner_t        last_owner;
   logic [HW-1:0] hold_cnt;
   disp_word_t    disp;
   logic          eff_a, eff_b, timeout_hit;
   logic          owning;

   disp_scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
      .clock     (clock),
      .areset    (areset),
      .clkenable (clkenable)
   );

   assign owning = (state == ST_OWN_A) || (state == ST_OWN_B);

`ifdef DISP_ARB_TIMEOUT_EN
   localparam int unsigned TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);

   logic [TW-1:0] to_cnt;
   logic          lock_a, lock_b;

   // A timed-out client stays locked out until its req is seen low once.
   always_ff @(posedge clock or negedge areset) begin
      if (!areset) begin
         to_cnt <= '0;
         lock_a <= 1'b0;
         lock_b <= 1'b0;
      end else begin
         if (!owning)                                 to_cnt <= '0;
         else if (clkenable && (to_cnt != TO_MAX))    to_cnt <= to_cnt + TW'(1);
         if (!req_a)                                  lock_a <= 1'b0;
         else if ((state == ST_OWN_A) && timeout_hit) lock_a <= 1'b1;
         if (!req_b)                                  lock_b <= 1'b0;
         else if ((state == ST_OWN_B) && timeout_hit) lock_b <= 1'b1;
      end
   end

   assign eff_a       = req_a & ~lock_a;
   assign eff_b       = req_b & ~lock_b;
   assign timeout_hit = (to_cnt == TO_MAX);
`else
   assign eff_a       = req_a;
   assign eff_b       = req_b;
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE, ST_SWITCH: nxt = pick_owner(eff_a, eff_b, last_owner);
         ST_OWN_A: if (!req_a || timeout_hit || (eff_b && (hold_cnt == HOLD_MAX))) nxt = ST_SWITCH;
         ST_OWN_B: if (!req_b || timeout_hit || (eff_a && (hold_cnt == HOLD_MAX))) nxt = ST_SWITCH;
         default:  nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge areset) begin
      if (!areset) begin
         state      <= ST_IDLE;
         last_owner <= OWNER_B;
         hold_cnt   <= '0;
         gnt_a      <= 1'b0;
         gnt_b      <= 1'b0;
         disp       <= IDLE_PATTERN;
      end else begin
         state <= nxt;
         gnt_a <= (nxt == ST_OWN_A);
         gnt_b <= (nxt == ST_OWN_B);
         if ((state == ST_OWN_A) && (nxt == ST_SWITCH)) last_owner <= OWNER_A;
         if ((state == ST_OWN_B) && (nxt == ST_SWITCH)) last_owner <= OWNER_B;
         if (!owning)                                    hold_cnt <= '0;
         else if (clkenable && (hold_cnt != HOLD_MAX))   hold_cnt <= hold_cnt + HW'(1);
         // SWITCH and the IDLE->OWN edge keep the last word; only a return to IDLE blanks it.
         case (state)
            ST_OWN_A: disp <= '{digits: data_a, dp: dpin_a, mode: mode_a};
            ST_OWN_B: disp <= '{digits: data_b, dp: dpin_b, mode: mode_b};
            default:  if (nxt == ST_IDLE) disp <= IDLE_PATTERN;
         endcase
      end
   end

   assign {d3, d2, d1, d0}     = disp.digits;
   assign {dp3, dp2, dp1, dp0} = disp.dp;
   assign mode                 = disp.mode;
   assign dbg_state            = state;

endmodule

// File: tb/tb_disp_arbiter.sv
// Bench for disp_arbiter: directed scenarios plus random traffic, all checked
// every cycle against an ownership-level model. Honours DISP_ARB_TIMEOUT_EN.
module tb_disp_arbiter;
  import disp_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int HOLD     = 2;
  localparam int TO       = 8;
`ifdef DISP_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock  = 1'b0;
  logic areset = 1'b0;
  always #5 clock = ~clock;

  logic        req_a = 1'b0, req_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic [3:0]  dpin_a = '0, dpin_b = '0;
  logic [1:0]  mode_a = '0, mode_b = '0;
  logic        gnt_a, gnt_b, dp3, dp2, dp1, dp0, clkenable;
  logic [3:0]  d3, d2, d1, d0;
  logic [1:0]  mode;
  disp_state_t dbg_state;

  disp_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD_TICKS(HOLD), .TIMEOUT_TICKS(TO)) dut (
    .clock(clock), .areset(areset),
    .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b),
    .dpin_a(dpin_a), .dpin_b(dpin_b),
    .mode_a(mode_a), .mode_b(mode_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .d3(d3), .d2(d2), .d1(d1), .d0(d0),
    .dp3(dp3), .dp2(dp2), .dp1(dp1), .dp0(dp0),
    .mode(mode), .clkenable(clkenable), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 none, 1 A, 2 B; sw marks the one-cycle handover gap.
  typedef struct {
    int          div;
    int          owner;
    bit          sw;
    int          ticks;
    int          last;
    bit          lock_a;
    bit          lock_b;
    logic [21:0] disp;
  } m_t;

  m_t m;

  function automatic m_t model_reset();
    m_t r;
    r.div = 0; r.owner = 0; r.sw = 1'b0; r.ticks = 0; r.last = 2;
    r.lock_a = 1'b0; r.lock_b = 1'b0; r.disp = '0;
    return r;
  endfunction

  function automatic m_t model_next(m_t c, logic ra, logic rb, logic [21:0] wa, logic [21:0] wb);
    m_t n = c;
    bit tick = (c.div == SCAN_DIV - 1);
    bit ea = ra && !(TO_EN && c.lock_a);
    bit eb = rb && !(TO_EN && c.lock_b);
    bit mine, other, timed;
    int pick;
    n.div = (c.div + 1) % SCAN_DIV;
    if (!ra) n.lock_a = 1'b0;
    if (!rb) n.lock_b = 1'b0;
    if (c.owner != 0) begin
      mine   = (c.owner == 1) ? ra : rb;
      other  = (c.owner == 1) ? eb : ea;
      timed  = TO_EN && (c.ticks >= TO);
      n.disp = (c.owner == 1) ? wa : wb;
      if (!mine || timed || (other && c.ticks >= HOLD)) begin
        n.owner = 0; n.sw = 1'b1; n.last = c.owner; n.ticks = 0;
        if (mine && timed) begin
          if (c.owner == 1) n.lock_a = 1'b1;
          else              n.lock_b = 1'b1;
        end
      end else if (tick) begin
        n.ticks = c.ticks + 1;
      end
    end else begin
      if (ea && eb)  pick = (c.last == 1) ? 2 : 1;
      else if (ea)   pick = 1;
      else if (eb)   pick = 2;
      else           pick = 0;
      n.owner = pick; n.sw = 1'b0; n.ticks = 0;
      if (pick == 0) n.disp = '0;
    end
    return n;
  endfunction

  always @(posedge clock or negedge areset) begin
    if (!areset) m <= model_reset();
    else         m <= model_next(m, req_a, req_b, {data_a, dpin_a, mode_a}, {data_b, dpin_b, mode_b});
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    chk("gnt_a", gnt_a, (m.owner == 1));
    chk("gnt_b", gnt_b, (m.owner == 2));
    chk("gnt_excl", gnt_a & gnt_b, 0);
    chk("clkenable", clkenable, (m.div == SCAN_DIV - 1));
    chk("display", {d3, d2, d1, d0, dp3, dp2, dp1, dp0, mode}, m.disp);
    chk("state", dbg_state, (m.owner == 1) ? ST_OWN_A : (m.owner == 2) ? ST_OWN_B :
                            m.sw ? ST_SWITCH : ST_IDLE);
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    areset = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    cyc(2);
    areset = 1'b1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int pulses, first_pos, last_pos, n, hi, ticks;
    cyc(3);
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_clken", clkenable, 0);
    chk("rst_digits", {d3, d2, d1, d0}, 16'h0000);
    areset = 1'b1;

    // free-running scan tick, no requests
    pulses = 0; first_pos = -1; last_pos = -1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (clkenable) begin
        pulses++;
        if (first_pos < 0) first_pos = i;
        last_pos = i;
      end
    end
    chk("clken_pulses", pulses, 3);
    chk("clken_first", first_pos, 3);
    chk("clken_period", last_pos - first_pos, 8);
    chk("idle_mode", mode, MODE_HEX);

    // single request, latency of grant and display
    req_a = 1'b1; data_a = 16'h1234; dpin_a = 4'b0100; mode_a = MODE_DEC;
    cyc(1);
    chk("a_gnt_lat", gnt_a, 1);
    chk("a_disp_lat_idle", {d3, d2, d1, d0}, 16'h0000);
    cyc(1);
    chk("a_digits", {d3, d2, d1, d0}, 16'h1234);
    chk("a_dp", {dp3, dp2, dp1, dp0}, 4'b0100);
    chk("a_mode", mode, MODE_DEC);
    req_a = 1'b0;
    cyc(1);
    chk("a_rel_gnt", gnt_a, 0);
    chk("a_rel_hold", {d3, d2, d1, d0}, 16'h1234);
    cyc(1);
    chk("a_rel_idle", {d3, d2, d1, d0}, 16'h0000);

    // simultaneous requests after reset: A first, held 2 scan ticks
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_b = 16'h5678;
    cyc(1);
    chk("both_a_first", gnt_a, 1);
    ticks = 0; n = 0;
    while (gnt_a && n < 100) begin
      if (clkenable) ticks++;
      cyc(1);
      n++;
    end
    chk("a_hold_ticks", ticks, HOLD);
    n = 0;
    while (!gnt_a && !gnt_b && n < 20) begin
      n++;
      cyc(1);
    end
    chk("switch_gap", n, 1);
    chk("b_after_switch", gnt_b, 1);

    // B drops: one held cycle, then idle pattern
    req_a = 1'b0; data_b = 16'hBEEF; dpin_b = 4'b1001; mode_b = MODE_OCT;
    cyc(3);
    chk("b_digits", {d3, d2, d1, d0}, 16'hBEEF);
    req_b = 1'b0;
    cyc(1);
    chk("b_rel_gnt", {gnt_a, gnt_b}, 2'b00);
    chk("b_rel_hold", {d3, d2, d1, d0, dp3, dp2, dp1, dp0}, {16'hBEEF, 4'b1001});
    cyc(1);
    chk("b_rel_idle", {d3, d2, d1, d0, dp3, dp2, dp1, dp0, mode}, 22'd0);

    // lone owner: timeout with lockout, or unbounded ownership
    req_a = 1'b1;
    cyc(1);
    chk("solo_gnt", gnt_a, 1);
`ifdef DISP_ARB_TIMEOUT_EN
    ticks = 0; n = 0;
    while (gnt_a && n < 100) begin
      if (clkenable) ticks++;
      cyc(1);
      n++;
    end
    chk("to_ticks", ticks, TO);
    hi = 0;
    repeat (20) begin
      cyc(1);
      hi += gnt_a;
    end
    chk("to_lockout", hi, 0);
    req_a = 1'b0;
    cyc(1);
    req_a = 1'b1;
    cyc(1);
    chk("to_regrant", gnt_a, 1);
`else
    hi = 0;
    repeat (44) begin
      cyc(1);
      hi += gnt_a;
    end
    chk("no_timeout", hi, 44);
`endif
    req_a = 1'b0;
    cyc(3);

    // asynchronous reset during B ownership
    req_b = 1'b1; data_b = 16'h9ABC;
    cyc(1);
    chk("arst_pre_gnt_b", gnt_b, 1);
    cyc(2);
    #2;
    areset = 1'b0;
    #1;
    chk("arst_gnt_b", gnt_b, 0);
    chk("arst_idle", {d3, d2, d1, d0, dp3, dp2, dp1, dp0, mode}, 22'd0);
    cyc(1);
    areset = 1'b1; req_a = 1'b1; req_b = 1'b1;
    cyc(1);
    chk("arst_a_wins", gnt_a, 1);
    req_a = 1'b0; req_b = 1'b0;
    cyc(3);

    // random traffic, including one-cycle drop/reassert
    for (int i = 0; i < 3000; i++) begin
      if (req_a) begin
        if ($urandom_range(0, 15) == 0) req_a = 1'b0;
      end else if ($urandom_range(0, 3) == 0) req_a = 1'b1;
      if (req_b) begin
        if ($urandom_range(0, 15) == 0) req_b = 1'b0;
      end else if ($urandom_range(0, 3) == 0) req_b = 1'b1;
      data_a = 16'($urandom); data_b = 16'($urandom);
      dpin_a = 4'($urandom_range(0, 15)); dpin_b = 4'($urandom_range(0, 15));
      mode_a = 2'($urandom_range(0, 2));  mode_b = 2'($urandom_range(0, 2));
      cyc(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
